// File: rtl/rr_arbiter4x2_pkg.sv
// Shared definitions for the 4-channel round-robin packet arbiter.
package rr_arbiter4x2_pkg;

  localparam int ARB_N = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } mode_t;

  // Rotate-priority search: first requester after ptr, ending with ptr
  // itself. Returns {found, idx}; idx is 0 when nothing is found.
  function automatic logic [SEL_W:0] rr_next(input logic [ARB_N-1:0] req,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = 1; i <= ARB_N; i++) begin
      idx = ptr + i[SEL_W-1:0];
      if (req[idx] && !res[SEL_W]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4x2_if.sv
// Handshake bundle between the upstream channels, the mux and the consumer.
import rr_arbiter4x2_pkg::*;

interface rr_arbiter4x2_if #(
  parameter int WIDTH = 2
);
  logic [ARB_N-1:0] V;
  logic [ARB_N-1:0] L;
  logic [ARB_N-1:0] R;
  logic [SEL_W-1:0] S;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] O;
  logic             OV;
  logic             ORDY;

  // Arbiter side: drives grants, mux select and the registered output.
  modport master (
    input  V, L, M, ORDY,
    output R, S, O, OV
  );

  // Environment side: upstream channels, mux and downstream consumer.
  modport slave (
    output V, L, M, ORDY,
    input  R, S, O, OV
  );
endinterface

// File: rtl/rr_arbiter4x2_pick4.sv
// Combinational rotate-priority encoder over the four channel valids.
import rr_arbiter4x2_pkg::*;

module rr_pick4 (
  input  logic [ARB_N-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] g
);

  assign {found, g} = rr_next(req, ptr);

endmodule

// File: rtl/rr_arbiter4x2.sv
// Round-robin packet-locking arbiter feeding a 4:1 mux select and
// registering the mux result into a one-entry output stage.
import rr_arbiter4x2_pkg::*;

module rr_arbiter4x2 #(
  parameter int WIDTH = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  rr_arbiter4x2_if.master bus
);

  mode_t            mode_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] lock_q;
  logic [WIDTH-1:0] o_q;
  logic             ov_q;

  logic             arb_found;
  logic [SEL_W-1:0] arb_g;
  logic             found;
  logic [SEL_W-1:0] g;
  logic             can_accept;
  logic             accept;

  rr_pick4 u_pick (
    .req   (bus.V),
    .ptr   (ptr_q),
    .found (arb_found),
    .g     (arb_g)
  );

  // Candidate selection: locked channel only while in a packet, otherwise
  // the round-robin winner; grant only when the output stage can take a beat.
  always_comb begin
    can_accept = !ov_q || bus.ORDY;
    if (mode_q == LOCK) begin
      found = bus.V[lock_q];
      g     = lock_q;
    end else begin
      found = arb_found;
      g     = arb_found ? arb_g : ptr_q;
    end
    accept = found && can_accept && !RESET;
    bus.S  = RESET ? '0 : g;
    bus.R  = accept ? (ARB_N'(1) << g) : '0;
  end

  // Mode/lock/pointer update and output register fill/drain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q <= ARB;
      ptr_q  <= SEL_W'(ARB_N - 1);
      lock_q <= '0;
      o_q    <= '0;
      ov_q   <= 1'b0;
    end else if (accept) begin
      o_q   <= bus.M;
      ov_q  <= 1'b1;
      ptr_q <= g;
      if (bus.L[g]) begin
        mode_q <= ARB;
      end else begin
        mode_q <= LOCK;
        lock_q <= g;
      end
    end else if (ov_q && bus.ORDY) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.O  = o_q;
  assign bus.OV = ov_q;

endmodule

// File: tb/tb_rr_arbiter4x2.sv
// Directed and randomized checks for rr_arbiter4x2 with a behavioural mux.
module tb_rr_arbiter4x2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] chdata [4];

  rr_arbiter4x2_if #(.WIDTH(2)) bus ();

  rr_arbiter4x2 #(.WIDTH(2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Mux model: the selected channel's data appears on M in the same cycle.
  assign bus.M = chdata[bus.S];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] er;
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    chdata[0] = 2'b10; chdata[1] = 2'b01; chdata[2] = 2'b00; chdata[3] = 2'b11;
    bus.V = 4'b1111; bus.L = 4'b1111; bus.ORDY = 1'b1;
    rst = 1'b1;
    step();
    step();
    total++; if (bus.R !== 4'b0000) begin bad++; $display("FAIL reset_R got=%b want=0000", bus.R); end
    total++; if (bus.S !== 2'd0) begin bad++; $display("FAIL reset_S got=%0d want=0", bus.S); end
    total++; if (bus.OV !== 1'b0) begin bad++; $display("FAIL reset_OV got=%b want=0", bus.OV); end
    total++; if (bus.O !== 2'b00) begin bad++; $display("FAIL reset_O got=%b want=00", bus.O); end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      er = 4'b0001 << exp_g[i];
      total++; if (bus.R !== er) begin bad++; $display("FAIL reset_seq_R[%0d] got=%b want=%b", i, bus.R, er); end
      total++; if (bus.S !== exp_g[i]) begin bad++; $display("FAIL reset_seq_S[%0d] got=%0d want=%0d", i, bus.S, exp_g[i]); end
      step();
      total++; if (bus.O !== chdata[exp_g[i]] || bus.OV !== 1'b1) begin
        bad++; $display("FAIL reset_seq_O[%0d] got=%b/%b want=%b/1", i, bus.O, bus.OV, chdata[exp_g[i]]);
      end
    end
    bus.V = 4'b0000;
    step();
  endtask

  task automatic test_rotation();
    logic [3:0] er;
    logic [1:0] exp_g [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset(2);
    chdata[1] = 2'b01; chdata[3] = 2'b11;
    bus.V = 4'b1010; bus.L = 4'b1111; bus.ORDY = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      er = 4'b0001 << exp_g[i];
      total++; if (bus.R !== er) begin bad++; $display("FAIL rot_R[%0d] got=%b want=%b", i, bus.R, er); end
      step();
      total++; if (bus.O !== chdata[exp_g[i]] || bus.OV !== 1'b1) begin
        bad++; $display("FAIL rot_O[%0d] got=%b/%b want=%b/1", i, bus.O, bus.OV, chdata[exp_g[i]]);
      end
    end
    bus.V = 4'b0000;
    step();
  endtask

  task automatic test_packet_lock();
    // ptr is 3 here; ch2 opens its packet alone, then ch0 competes.
    chdata[0] = 2'b10;
    bus.ORDY = 1'b1;
    chdata[2] = 2'b01; bus.V = 4'b0100; bus.L = 4'b0000;
    #1;
    total++; if (bus.R !== 4'b0100) begin bad++; $display("FAIL lock_b0_R got=%b want=0100", bus.R); end
    step();
    total++; if (bus.O !== 2'b01) begin bad++; $display("FAIL lock_b0_O got=%b want=01", bus.O); end
    chdata[2] = 2'b10; bus.V = 4'b0101; bus.L = 4'b0001;
    #1;
    total++; if (bus.R !== 4'b0100) begin bad++; $display("FAIL lock_b1_R got=%b want=0100", bus.R); end
    step();
    total++; if (bus.O !== 2'b10) begin bad++; $display("FAIL lock_b1_O got=%b want=10", bus.O); end
    bus.V = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (bus.R !== 4'b0000) begin bad++; $display("FAIL lock_stall_R[%0d] got=%b want=0000", i, bus.R); end
      total++; if (bus.S !== 2'd2) begin bad++; $display("FAIL lock_stall_S[%0d] got=%0d want=2", i, bus.S); end
      step();
    end
    total++; if (bus.OV !== 1'b0) begin bad++; $display("FAIL lock_stall_OV got=%b want=0", bus.OV); end
    chdata[2] = 2'b11; bus.V = 4'b0101; bus.L = 4'b0101;
    #1;
    total++; if (bus.R !== 4'b0100) begin bad++; $display("FAIL lock_b2_R got=%b want=0100", bus.R); end
    step();
    total++; if (bus.O !== 2'b11) begin bad++; $display("FAIL lock_b2_O got=%b want=11", bus.O); end
    bus.V = 4'b0001;
    #1;
    total++; if (bus.R !== 4'b0001) begin bad++; $display("FAIL lock_after_R got=%b want=0001", bus.R); end
    step();
    total++; if (bus.O !== 2'b10) begin bad++; $display("FAIL lock_after_O got=%b want=10", bus.O); end
    bus.V = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    // ptr is 0 here.
    chdata[1] = 2'b01; chdata[3] = 2'b11;
    bus.V = 4'b0010; bus.L = 4'b1111; bus.ORDY = 1'b1;
    #1;
    total++; if (bus.R !== 4'b0010) begin bad++; $display("FAIL bp_first_R got=%b want=0010", bus.R); end
    step();
    bus.ORDY = 1'b0; bus.V = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (bus.R !== 4'b0000) begin bad++; $display("FAIL bp_full_R[%0d] got=%b want=0000", i, bus.R); end
      total++; if (bus.S !== 2'd3) begin bad++; $display("FAIL bp_full_S[%0d] got=%0d want=3", i, bus.S); end
      step();
      total++; if (bus.O !== 2'b01 || bus.OV !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%b want=01/1", i, bus.O, bus.OV);
      end
    end
    bus.ORDY = 1'b1;
    #1;
    total++; if (bus.R !== 4'b1000) begin bad++; $display("FAIL bp_release_R got=%b want=1000", bus.R); end
    step();
    total++; if (bus.O !== 2'b11 || bus.OV !== 1'b1) begin
      bad++; $display("FAIL bp_refill got=%b/%b want=11/1", bus.O, bus.OV);
    end
    bus.V = 4'b0000;
    step();
    total++; if (bus.OV !== 1'b0) begin bad++; $display("FAIL bp_drain_OV got=%b want=0", bus.OV); end
  endtask

  task automatic test_reset_mid_packet();
    // ptr is 3 here; ch1 opens a packet.
    chdata[0] = 2'b10; chdata[1] = 2'b01;
    bus.V = 4'b0010; bus.L = 4'b0000; bus.ORDY = 1'b1;
    step();
    bus.V = 4'b0011;
    #1;
    total++; if (bus.R !== 4'b0010) begin bad++; $display("FAIL rmp_locked_R got=%b want=0010", bus.R); end
    rst = 1'b1;
    #1;
    total++; if (bus.R !== 4'b0000 || bus.S !== 2'd0) begin
      bad++; $display("FAIL rmp_inreset got=%b/%0d want=0000/0", bus.R, bus.S);
    end
    step();
    total++; if (bus.OV !== 1'b0 || bus.O !== 2'b00) begin
      bad++; $display("FAIL rmp_out got=%b/%b want=0/00", bus.OV, bus.O);
    end
    rst = 1'b0; bus.L = 4'b1111;
    #1;
    total++; if (bus.R !== 4'b0001 || bus.S !== 2'd0) begin
      bad++; $display("FAIL rmp_first got=%b/%0d want=0001/0", bus.R, bus.S);
    end
    step();
    total++; if (bus.O !== 2'b10) begin bad++; $display("FAIL rmp_first_O got=%b want=10", bus.O); end
    bus.V = 4'b0000;
    step();
  endtask

  task automatic test_random();
    logic [1:0] m_ptr, m_lock, m_o;
    logic       m_lockd, m_ov;
    logic       f;
    logic [1:0] cg, es, idx;
    logic [3:0] er, seen_r;
    logic       can;
    do_reset(1);
    m_ptr = 2'd3; m_lock = 2'd0; m_lockd = 1'b0; m_o = 2'b00; m_ov = 1'b0;
    bus.V = 4'b0000; bus.L = 4'b0000;
    seen_r = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(bus.V[k] && !seen_r[k])) begin
          bus.V[k]  = ($urandom_range(0, 99) < 60);
          bus.L[k]  = ($urandom_range(0, 99) < 40);
          chdata[k] = 2'($urandom_range(0, 3));
        end
      end
      bus.ORDY = ($urandom_range(0, 99) < 70);
      #1;
      f = 1'b0; cg = 2'd0;
      if (m_lockd) begin
        f = bus.V[m_lock]; cg = m_lock;
      end else begin
        for (int i = 1; i <= 4; i++) begin
          idx = m_ptr + 2'(i);
          if (!f && bus.V[idx]) begin f = 1'b1; cg = idx; end
        end
      end
      es  = f ? cg : (m_lockd ? m_lock : m_ptr);
      can = !m_ov || bus.ORDY;
      er  = (f && can) ? (4'b0001 << cg) : 4'b0000;
      total++; if (bus.R !== er) begin bad++; $display("FAIL rnd_R c=%0d got=%b want=%b", c, bus.R, er); end
      total++; if (bus.S !== es) begin bad++; $display("FAIL rnd_S c=%0d got=%0d want=%0d", c, bus.S, es); end
      total++; if (!$onehot0(bus.R)) begin bad++; $display("FAIL rnd_onehot c=%0d got=%b want=onehot0", c, bus.R); end
      seen_r = bus.R;
      if (f && can) begin
        m_o = chdata[cg]; m_ov = 1'b1; m_ptr = cg;
        m_lockd = !bus.L[cg];
        m_lock  = cg;
      end else if (m_ov && bus.ORDY) begin
        m_ov = 1'b0;
      end
      step();
      total++; if (bus.OV !== m_ov) begin bad++; $display("FAIL rnd_OV c=%0d got=%b want=%b", c, bus.OV, m_ov); end
      total++; if (bus.O !== m_o) begin bad++; $display("FAIL rnd_O c=%0d got=%b want=%b", c, bus.O, m_o); end
    end
    bus.V = 4'b0000;
    step();
  endtask

  initial begin
    bus.V = 4'b0000; bus.L = 4'b0000; bus.ORDY = 1'b0;
    for (int k = 0; k < 4; k++) chdata[k] = 2'b00;
    #1;
    test_reset();
    test_rotation();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
